// File: rtl/pattern_scan_ctrl_if.sv
// Word-in / result-out handshake bundle for the serial pattern scanner.
// The master side is the word source plus the result consumer; the slave side is the controller.
interface pattern_scan_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = $clog2(DATA_W + 1)
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_mask;
  logic [CNT_W-1:0]  out_count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_mask, out_count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_mask, out_count
  );
endinterface

// File: rtl/pattern_scan_ctrl.sv
// Scans each accepted word LSB-first, one bit per cycle, against a programmable pattern.
// Returns a per-bit match mask and match count over the result handshake.
module pattern_scan_ctrl #(
  parameter int               DATA_W  = 16,
  parameter int               PAT_W   = 3,
  parameter logic [PAT_W-1:0] PAT_RST = 3'b101,
  parameter int               CNT_W   = $clog2(DATA_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cfg_we,
  input  logic [PAT_W-1:0] i_cfg_pattern,
  input  logic             i_abort,
  output logic             o_busy,
  pattern_scan_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(DATA_W);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [IDX_W-1:0]  IDX_FIRST_MATCH = IDX_W'(PAT_W - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST        = IDX_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] MASK_ONE        = DATA_W'(1);

  logic [1:0]        r_state;
  logic [PAT_W-1:0]  r_pattern;
  logic [DATA_W-1:0] r_data;
  logic [PAT_W-2:0]  r_win;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_mask;
  logic [CNT_W-1:0]  r_count;

  logic [PAT_W-1:0]  w_cand;
  logic              w_match;

  // The scan register shifts right, so the bit under test is always at position 0.
  assign w_cand  = {r_win, r_data[0]};
  assign w_match = (r_idx >= IDX_FIRST_MATCH) && (w_cand == r_pattern);

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.out_mask  = r_mask;
  assign bus.out_count = r_count;
  assign o_busy        = (r_state != ST_IDLE);

  // Sequencing FSM, pattern configuration and scan datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pattern <= PAT_RST;
      r_data    <= '0;
      r_win     <= '0;
      r_idx     <= '0;
      r_mask    <= '0;
      r_count   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_cfg_we) begin
            r_pattern <= i_cfg_pattern;
          end
          if (bus.in_valid) begin
            r_data  <= bus.in_data;
            r_win   <= '0;
            r_idx   <= '0;
            r_mask  <= '0;
            r_count <= '0;
            r_state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (i_abort) begin
            r_win   <= '0;
            r_idx   <= '0;
            r_mask  <= '0;
            r_count <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_data <= r_data >> 1;
            r_win  <= w_cand[PAT_W-2:0];
            r_idx  <= r_idx + IDX_W'(1);
            if (w_match) begin
              r_mask  <= r_mask | (MASK_ONE << r_idx);
              r_count <= r_count + CNT_W'(1);
            end
            if (r_idx == IDX_LAST) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Self-checking bench for pattern_scan_ctrl: directed vector table, multi-cycle corner
// sequences and randomized words scored against a window-by-window reference model.
module tb_pattern_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       cfg_we;
  logic [2:0] cfg_pattern;
  logic       abort;
  logic       busy;

  int errors = 0;
  int checks = 0;

  pattern_scan_ctrl_if #(.DATA_W(16), .CNT_W(5)) bus ();

  pattern_scan_ctrl #(
    .DATA_W(16), .PAT_W(3), .PAT_RST(3'b101), .CNT_W(5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_cfg_we      (cfg_we),
    .i_cfg_pattern (cfg_pattern),
    .i_abort       (abort),
    .o_busy        (busy),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  typedef struct {
    logic        cfg;
    logic [2:0]  pat;
    logic [15:0] data;
    logic [15:0] mask;
    logic [4:0]  count;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: a match ends at bit i when bits i-2, i-1, i (earliest first) spell the pattern.
  function automatic logic [15:0] model_mask(input logic [15:0] d, input logic [2:0] p);
    logic [15:0] m;
    logic [2:0]  v;
    m = 16'h0000;
    for (int i = 2; i < 16; i++) begin
      v = {d[i-2], d[i-1], d[i]};
      if (v == p) m[i] = 1'b1;
    end
    return m;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_busy"},      32'(busy),          32'd0);
    chk({tag, "_mask"},      32'(bus.out_mask),  32'd0);
    chk({tag, "_count"},     32'(bus.out_count), 32'd0);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("ready_timeout", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic set_pattern(input logic [2:0] p);
    wait_ready();
    cfg_we      = 1'b1;
    cfg_pattern = p;
    @(negedge clk);
    cfg_we      = 1'b0;
  endtask

  task automatic offer_and_accept(input logic [15:0] d, input logic use_cfg, input logic [2:0] p);
    wait_ready();
    if (use_cfg) begin
      cfg_we      = 1'b1;
      cfg_pattern = p;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    cfg_we       = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = ~d;
    chk("accept_in_ready", 32'(bus.in_ready), 32'd0);
    chk("accept_busy",     32'(busy),         32'd1);
  endtask

  // Counts negedges after the accept edge until out_valid; optionally pokes cfg_we mid-scan.
  task automatic wait_result(input logic scan_cfg);
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      if (scan_cfg && lat == 3) begin
        cfg_we      = 1'b1;
        cfg_pattern = 3'b000;
      end else begin
        cfg_we = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    cfg_we = 1'b0;
    chk("latency", 32'(lat), 32'd16);
  endtask

  task automatic take_result(input string tag, input logic [15:0] em, input logic [4:0] ec,
                             input int delay);
    chk({tag, "_mask"},  32'(bus.out_mask),  32'(em));
    chk({tag, "_count"}, 32'(bus.out_count), 32'(ec));
    for (int k = 0; k < delay; k++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_hold_ready"}, 32'(bus.in_ready),  32'd0);
      chk({tag, "_hold_mask"},  32'(bus.out_mask),  32'(em));
      chk({tag, "_hold_count"}, 32'(bus.out_count), 32'(ec));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_post_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_post_ready"}, 32'(bus.in_ready),  32'd1);
  endtask

  task automatic run_word(input string tag, input logic [15:0] d, input logic scan_cfg,
                          input logic [15:0] em, input logic [4:0] ec);
    offer_and_accept(d, 1'b0, 3'b000);
    wait_result(scan_cfg);
    take_result(tag, em, ec, 0);
  endtask

  initial begin
    logic [2:0]  cur_p;
    logic [2:0]  p;
    logic [15:0] d;
    logic [15:0] em;
    int          mode;
    int          seen;

    tbl[0] = '{1'b0, 3'b101, 16'h0005, 16'h0004, 5'd1};
    tbl[1] = '{1'b0, 3'b101, 16'hAAAA, 16'hAAA8, 5'd7};
    tbl[2] = '{1'b1, 3'b111, 16'hFFFF, 16'hFFFC, 5'd14};
    tbl[3] = '{1'b1, 3'b101, 16'h8000, 16'h0000, 5'd0};
    tbl[4] = '{1'b0, 3'b101, 16'h0001, 16'h0000, 5'd0};

    rst           = 1'b1;
    cfg_we        = 1'b0;
    cfg_pattern   = 3'b000;
    abort         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 16'h0000;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_idle("reset");

    for (int i = 0; i < 5; i++) begin
      if (tbl[i].cfg) set_pattern(tbl[i].pat);
      run_word($sformatf("vec%0d", i), tbl[i].data, 1'b0, tbl[i].mask, tbl[i].count);
    end

    // cfg_we during a scan must not touch the active pattern
    set_pattern(3'b111);
    run_word("scan_cfg",  16'hFFFF, 1'b1, 16'hFFFC, 5'd14);
    run_word("after_cfg", 16'hFFFF, 1'b0, 16'hFFFC, 5'd14);

    // Backpressure with a second word offered while blocked
    set_pattern(3'b101);
    offer_and_accept(16'hAAAA, 1'b0, 3'b000);
    wait_result(1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0005;
    take_result("bp", 16'hAAA8, 5'd7, 5);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 16'h0000;
    chk("bp_late_accept_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_late_accept_busy",  32'(busy),         32'd1);
    wait_result(1'b0);
    take_result("bp_second", 16'h0004, 5'd1, 0);

    // Reset in the middle of a scan restores the default pattern
    set_pattern(3'b111);
    offer_and_accept(16'hAAAA, 1'b0, 3'b000);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_idle("midscan_reset");
    run_word("post_reset", 16'h0005, 1'b0, 16'h0004, 5'd1);

    // Abort five cycles into a scan
    offer_and_accept(16'hAAAA, 1'b0, 3'b000);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_idle("abort");
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("abort_no_valid", 32'(seen), 32'd0);
    run_word("post_abort", 16'h0005, 1'b0, 16'h0004, 5'd1);

    // Randomized words and patterns against the reference model
    cur_p = 3'b101;
    for (int it = 0; it < 40; it++) begin
      p    = 3'($urandom_range(0, 7));
      d    = 16'($urandom);
      mode = $urandom_range(0, 2);
      if (mode == 1) begin
        set_pattern(p);
        cur_p = p;
      end
      if (mode == 2) cur_p = p;
      em = model_mask(d, cur_p);
      offer_and_accept(d, (mode == 2), p);
      wait_result(1'b0);
      take_result($sformatf("rand%0d", it), em, 5'($countones(em)), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pattern_scan_ctrl.md
# pattern_scan_ctrl

Sequencing controller for the serial bit-pattern detector. It accepts 16-bit words over a valid/ready handshake and scans each word LSB-first, one bit per cycle, against a programmable PAT_W-bit pattern. For every word it returns a per-bit match mask and a match count over a second valid/ready handshake. It sits between the word source and any consumer of match results, and owns pattern configuration, scan sequencing and backpressure.

## Interface
- DATA_W, 16, word width / scan length in cycles
- PAT_W, 3, pattern length (2..DATA_W)
- PAT_RST, 3'b101, pattern value loaded at reset
- CNT_W, $clog2(DATA_W+1), width of match count
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  pattern write strobe, honoured only in IDLE
- cfg_pattern  in  PAT_W  new pattern value
- in_valid  in  1  word available
- in_data  in  DATA_W  word to scan
- in_ready  out  1  controller can accept a word
- abort  in  1  cancel scan in progress
- out_valid  out  1  scan result available
- out_ready  in  1  consumer takes result
- out_mask  out  DATA_W  bit i set = pattern ends at bit i
- out_count  out  CNT_W  popcount of out_mask
- busy  out  1  state != IDLE

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: in_ready=1. cfg_we=1 loads cfg_pattern into the active pattern register. in_valid=1 latches in_data into the scan register and clears mask, count, window and bit index, then goes to SCAN. If cfg_we and in_valid occur together, the new pattern applies to that word.
- SCAN: in_ready=0. cfg_we is ignored. Each cycle, bit i = data[i] is processed, i = 0..DATA_W-1.
  - Window update: w <= {w[PAT_W-2:0], data[i]}. The earliest bit sits at the MSB.
  - Match condition: (i >= PAT_W-1) and ({w[PAT_W-2:0], data[i]} == pattern). On a match, set mask[i] and increment count.
  - Overlapping matches are counted. No match spans two words, because the window clears on each accept.
  - After bit DATA_W-1, go to DONE.
- abort=1 in SCAN: go to IDLE next edge. No out_valid is produced. The partial mask and count are discarded, and out_mask/out_count are cleared to 0. abort is ignored in IDLE and DONE.
- DONE: out_valid=1. out_mask and out_count are stable. When out_ready=1, go to IDLE.
- out_mask and out_count hold their last values in IDLE. They clear on the next accept.
- Count never overflows: max = DATA_W-PAT_W+1 < 2^CNT_W.

## Timing
- Reset values (the cycle after an edge with rst=1, from any state including mid-SCAN):
  - State IDLE, so in_ready=1.
  - out_valid=0, busy=0, out_mask=0, out_count=0.
  - Pattern = PAT_RST. Window, index and scan register are 0.
- rst has priority over abort, cfg_we and both handshakes.
- Accept at edge T (in_valid & in_ready): in_ready=0 and busy=1 from T+1.
- Bits 0..DATA_W-1 are processed at edges T+1..T+DATA_W. out_valid=1 from T+DATA_W, i.e. 16 cycles after accept.
- Result handshake at edge T+DATA_W+k (k>=1, first edge with out_ready=1): out_valid=0 and in_ready=1 from that edge.
- The earliest next accept is one edge later. Maximum throughput is one word per DATA_W+2 cycles with out_ready tied high.
- in_data is sampled only at the accept edge; later changes have no effect.
- Abort sampled at edge T+j (1<=j<=DATA_W): state is IDLE after that edge. The bit scheduled at that edge is not processed.
- No combinational path from any input to any output. All outputs are registered or decoded from state only.

## Test plan
- Reset: hold rst for 2 cycles, including once mid-SCAN. Required after each: in_ready=1, out_valid=0, busy=0, out_mask=0, out_count=0, pattern 3'b101.
- Default pattern: send 16'h0005, then 16'hAAAA, with out_ready=1.
  - 16'h0005 -> out_mask=16'h0004, out_count=1.
  - 16'hAAAA -> out_mask=16'hAAA8, out_count=7.
  - out_valid rises exactly 16 cycles after each accept edge.
- Overlap and config: in IDLE, write cfg_pattern=3'b111, then send 16'hFFFF -> out_mask=16'hFFFC, out_count=14. Assert cfg_we=1 with 3'b000 during SCAN; a following 16'hFFFF still gives count 14.
- Backpressure and word boundaries:
  - Hold out_ready=0 for 5 cycles after out_valid. out_mask, out_count and out_valid stay stable, and in_ready=0 throughout.
  - Offer a second word while blocked; it is not accepted until one edge after the result handshake.
  - Send 16'h8000 then 16'h0001 with pattern 3'b101 -> both results give out_count=0 (no cross-word match).
- Abort: assert abort 5 cycles into a scan of 16'hAAAA. Required: no out_valid; in_ready=1 on the next cycle; out_mask=0 and out_count=0. A following 16'h0005 gives out_mask=16'h0004, out_count=1.
